// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the combinational ALU and the execute stage.
//   DATA_W_DFLT : default operand/result width
//   REG_W_DFLT  : default destination register index width
//   OP_*        : 4-bit ALU opcodes
//   is_legal_op : 1 when an opcode belongs to the defined set
package alu_pkg;

    localparam int DATA_W_DFLT = 32;
    localparam int REG_W_DFLT  = 5;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_CBZ  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_ORR  = 4'b0100;
    localparam logic [3:0] OP_EOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_CBZ, OP_SUB, OP_AND, OP_ORR,
            OP_EOR, OP_NOR, OP_NAND, OP_MOV: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_stats.sv
// alu_exec_stats: event counters for the execute stage.
//   clk, rst_n    : clock, asynchronous active-low reset
//   stat_clr      : synchronous clear of all counters, wins over increments
//   issue_evt     : an operation was accepted into S1 (stat_issued, wraps)
//   illegal_evt   : S2 captured an illegal opcode (stat_illegal, saturates)
//   stall_evt     : S2 held a result that writeback refused (stat_stall, wraps)
module alu_exec_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stat_clr,
    input  logic        issue_evt,
    input  logic        illegal_evt,
    input  logic        stall_evt,
    output logic [31:0] stat_issued,
    output logic [15:0] stat_illegal,
    output logic [31:0] stat_stall
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued  <= '0;
            stat_illegal <= '0;
            stat_stall   <= '0;
        end else if (stat_clr) begin
            stat_issued  <= '0;
            stat_illegal <= '0;
            stat_stall   <= '0;
        end else begin
            if (issue_evt) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (illegal_evt && (stat_illegal != 16'hFFFF)) begin
                stat_illegal <= stat_illegal + 16'd1;
            end
            if (stall_evt) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-stage execute pipeline around the combinational ALU.
// S1 registers the decoded operation and drives it onto the ALU ports; S2
// captures the ALU result plus rd/flags and offers them to writeback.
// No forwarding: hazards are resolved before decode issues.
//
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   in_valid/in_ready            : decode handshake
//   in_opcode, in_op_a, in_op_b  : operation to execute
//   in_rd                        : destination register
//   alu_opcode, alu_in_one/two   : registered ALU inputs (hold when S1 empty)
//   alu_result                   : combinational ALU result
//   out_valid/out_ready          : writeback handshake
//   out_result, out_rd           : captured result and destination
//   out_wr_en                    : result should be written (not CBZ, legal)
//   out_branch_taken             : CBZ with alu_result[0] set
//   out_illegal                  : opcode outside the defined set
//   stat_clr, stat_issued, stat_illegal, stat_stall
//                                : only when ALU_EXEC_STATS_EN is defined
//
// Build option: `define ALU_EXEC_STATS_EN to compile in the counters.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int REG_W  = REG_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [DATA_W-1:0] in_op_a,
    input  logic [DATA_W-1:0] in_op_b,
    input  logic [REG_W-1:0]  in_rd,
    output logic [DATA_W-1:0] alu_in_one,
    output logic [DATA_W-1:0] alu_in_two,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_wr_en,
    output logic              out_branch_taken,
    output logic              out_illegal
`ifdef ALU_EXEC_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [31:0]       stat_issued,
    output logic [15:0]       stat_illegal,
    output logic [31:0]       stat_stall
`endif
);

    logic             s1_valid;
    logic [REG_W-1:0] s1_rd;
    logic             s2_free;
    logic             s1_adv;
    logic             accept;
    logic             s1_is_cbz;
    logic             s1_illegal;

    assign s2_free    = !out_valid || out_ready;
    assign s1_adv     = s1_valid && s2_free;
    assign in_ready   = !s1_valid || s1_adv;
    assign accept     = in_valid && in_ready;
    assign s1_is_cbz  = (alu_opcode == OP_CBZ);
    assign s1_illegal = !is_legal_op(alu_opcode);

    // S1: the ALU input ports are the S1 registers themselves, so they keep
    // their last values while S1 is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            alu_opcode <= '0;
            alu_in_one <= '0;
            alu_in_two <= '0;
            s1_rd      <= '0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            alu_opcode <= in_opcode;
            alu_in_one <= in_op_a;
            alu_in_two <= in_op_b;
            s1_rd      <= in_rd;
        end else if (s1_adv) begin
            s1_valid   <= 1'b0;
        end
    end

    // S2: payload only changes on capture, so it stays stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            out_result       <= '0;
            out_rd           <= '0;
            out_wr_en        <= 1'b0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b0;
        end else if (s1_adv) begin
            out_valid        <= 1'b1;
            out_result       <= alu_result;
            out_rd           <= s1_rd;
            out_wr_en        <= !s1_is_cbz && !s1_illegal;
            out_branch_taken <= s1_is_cbz && alu_result[0];
            out_illegal      <= s1_illegal;
        end else if (out_ready) begin
            out_valid        <= 1'b0;
        end
    end

`ifdef ALU_EXEC_STATS_EN
    alu_exec_stats u_stats (
        .clk          (clk),
        .rst_n        (rst_n),
        .stat_clr     (stat_clr),
        .issue_evt    (accept),
        .illegal_evt  (s1_adv && s1_illegal),
        .stall_evt    (out_valid && !out_ready),
        .stat_issued  (stat_issued),
        .stat_illegal (stat_illegal),
        .stat_stall   (stat_stall)
    );
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

    localparam logic [3:0] ADD = 4'b0010, CBZ = 4'b0111, SUB = 4'b1010, AND_ = 4'b0110,
                           ORR = 4'b0100, EOR = 4'b1001, NOR_ = 4'b0101, NAND_ = 4'b1100,
                           MOV = 4'b1101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opcode = '0;
    logic [31:0] in_op_a = '0;
    logic [31:0] in_op_b = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] alu_in_one, alu_in_two, alu_result;
    logic [3:0]  alu_opcode;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wr_en, out_branch_taken, out_illegal;
    logic        stat_clr = 1'b0;
`ifdef ALU_EXEC_STATS_EN
    logic [31:0] stat_issued, stat_stall;
    logic [15:0] stat_illegal;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_opcode        (in_opcode),
        .in_op_a          (in_op_a),
        .in_op_b          (in_op_b),
        .in_rd            (in_rd),
        .alu_in_one       (alu_in_one),
        .alu_in_two       (alu_in_two),
        .alu_opcode       (alu_opcode),
        .alu_result       (alu_result),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_rd           (out_rd),
        .out_wr_en        (out_wr_en),
        .out_branch_taken (out_branch_taken),
        .out_illegal      (out_illegal)
`ifdef ALU_EXEC_STATS_EN
        ,
        .stat_clr         (stat_clr),
        .stat_issued      (stat_issued),
        .stat_illegal     (stat_illegal),
        .stat_stall       (stat_stall)
`endif
    );

    // Reference ALU: also serves as the environment driving alu_result.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND_:    return a & b;
            ORR:     return a | b;
            EOR:     return a ^ b;
            NOR_:    return ~(a | b);
            NAND_:   return ~(a & b);
            MOV:     return b;
            CBZ:     return (a == 32'd0) ? 32'd1 : 32'd0;
            default: return 32'hDEAD0000 | {28'd0, op};
        endcase
    endfunction

    function automatic bit legal(input logic [3:0] op);
        return op inside {ADD, CBZ, SUB, AND_, ORR, EOR, NOR_, NAND_, MOV};
    endfunction

    assign alu_result = ref_alu(alu_opcode, alu_in_one, alu_in_two);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in-flight operations in order, each tagged with the cycle it was accepted.
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, res;
        logic [4:0]  rd;
        int          acc;
    } op_t;

    op_t q[$];
    int  cyc = 0;
    longint m_iss = 0, m_ill = 0, m_stl = 0;

    always @(negedge clk) begin
        bit  exp_ov, exp_ir, s1_occ, cap, acc_now;
        op_t e;
        if (!rst_n) begin
            q.delete();
            m_iss = 0; m_ill = 0; m_stl = 0;
            cyc = 0;
        end else begin
            // An op spends exactly one cycle in S1 unless S2 already holds an older one.
            exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
            exp_ir = (q.size() < 2) || out_ready;
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, exp_ir);
            if (exp_ov && out_valid) begin
                chk("out_result", out_result, q[0].res);
                chk("out_rd", out_rd, q[0].rd);
                chk("out_wr_en", out_wr_en, q[0].op != CBZ && legal(q[0].op));
                chk("out_branch_taken", out_branch_taken, q[0].op == CBZ && q[0].res[0]);
                chk("out_illegal", out_illegal, !legal(q[0].op));
            end
            if (q.size() > 0 && q[$].acc == cyc - 1) begin
                chk("alu_opcode", alu_opcode, q[$].op);
                chk("alu_in_one", alu_in_one, q[$].a);
                chk("alu_in_two", alu_in_two, q[$].b);
            end
`ifdef ALU_EXEC_STATS_EN
            chk("stat_issued", stat_issued, m_iss[31:0]);
            chk("stat_illegal", stat_illegal, m_ill[15:0]);
            chk("stat_stall", stat_stall, m_stl[31:0]);
`endif
            s1_occ  = (q.size() == 2) || (q.size() == 1 && !exp_ov);
            cap     = s1_occ && (!exp_ov || out_ready);
            acc_now = in_valid && exp_ir;
            if (stat_clr) begin
                m_iss = 0; m_ill = 0; m_stl = 0;
            end else begin
                if (acc_now) m_iss = (m_iss + 1) % (64'd1 << 32);
                if (cap && !legal(q[q.size()-1].op) && m_ill < 65535) m_ill++;
                if (exp_ov && !out_ready) m_stl = (m_stl + 1) % (64'd1 << 32);
            end
            if (exp_ov && out_ready) void'(q.pop_front());
            if (acc_now) begin
                e.op = in_opcode; e.a = in_op_a; e.b = in_op_b; e.rd = in_rd;
                e.res = ref_alu(in_opcode, in_op_a, in_op_b);
                e.acc = cyc;
                q.push_back(e);
            end
            cyc++;
        end
    end

    // Each step starts just after a rising edge and ends just after the next one.
    task automatic step(input bit v, input bit r, input bit clr, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid = v; out_ready = r; stat_clr = clr;
        in_opcode = op; in_op_a = a; in_op_b = b; in_rd = rd;
        @(posedge clk); #1;
    endtask

    task automatic rstep(input bit v, input bit r, input bit clr);
        logic [31:0] a;
        a = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
        step(v, r, clr, 4'($urandom_range(0, 15)), a, 32'($urandom), 5'($urandom_range(0, 31)));
    endtask

    task automatic drain();
        repeat (4) step(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    endtask

    initial begin
        // Reset values
        #3;
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_result", out_result, 0);
        chk("rst alu_opcode", alu_opcode, 0);
        chk("rst alu_in_one", alu_in_one, 0);
`ifdef ALU_EXEC_STATS_EN
        chk("rst stat_issued", stat_issued, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD 15+15: valid from the second edge after the accept edge
        step(1'b1, 1'b1, 1'b0, ADD, 32'd15, 32'd15, 5'd3);
        in_valid = 1'b0;
        @(negedge clk); chk("add latency early", out_valid, 0);
        @(negedge clk);
        chk("add out_valid", out_valid, 1);
        chk("add out_result", out_result, 30);
        chk("add out_wr_en", out_wr_en, 1);
        chk("add out_rd", out_rd, 3);
        @(posedge clk); #1;

        // CBZ taken / not taken
        step(1'b1, 1'b1, 1'b0, CBZ, 32'd0, 32'd7, 5'd4);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("cbz0 branch", out_branch_taken, 1);
        chk("cbz0 wr_en", out_wr_en, 0);
        @(posedge clk); #1;
        step(1'b1, 1'b1, 1'b0, CBZ, 32'd10, 32'd7, 5'd4);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("cbz10 branch", out_branch_taken, 0);
        @(posedge clk); #1;
        drain();

        // Back-to-back at full rate
        step(1'b1, 1'b1, 1'b0, SUB, 32'd100, 32'd1, 5'd5);
        step(1'b1, 1'b1, 1'b0, AND_, 32'hF0F0, 32'hFF00, 5'd6);
        step(1'b1, 1'b1, 1'b0, ORR, 32'h0F00, 32'h00F0, 5'd7);
        drain();

        // Backpressure: 5 cycles of out_ready=0 with continuous in_valid
        step(1'b0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0);
        repeat (5) rstep(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp held count", q.size(), 2);
        chk("bp in_ready", in_ready, 0);
        chk("bp out_valid", out_valid, 1);
`ifdef ALU_EXEC_STATS_EN
        chk("bp stat_stall", stat_stall, 3);
`endif
        @(posedge clk); #1;
        drain();

        // Illegal opcode, then clear
        step(1'b0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0);
        step(1'b1, 1'b1, 1'b0, 4'b0000, 32'd1, 32'd2, 5'd9);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("ill out_illegal", out_illegal, 1);
        chk("ill out_wr_en", out_wr_en, 0);
`ifdef ALU_EXEC_STATS_EN
        chk("ill stat_illegal", stat_illegal, 1);
`endif
        @(posedge clk); #1;
        step(1'b0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
`ifdef ALU_EXEC_STATS_EN
        chk("clr stat_issued", stat_issued, 0);
        chk("clr stat_illegal", stat_illegal, 0);
        chk("clr stat_stall", stat_stall, 0);
`endif
        @(posedge clk); #1;

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            rstep($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 63) == 0);
        end
        drain();

        // Reset with both stages full
        rstep(1'b1, 1'b0, 1'b0);
        rstep(1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst out_result", out_result, 0);
        chk("mid rst out_rd", out_rd, 0);
        chk("mid rst out_flags", {out_wr_en, out_branch_taken, out_illegal}, 0);
        chk("mid rst alu_opcode", alu_opcode, 0);
        chk("mid rst alu_in_two", alu_in_two, 0);
        chk("mid rst in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) step(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        chk("post rst no output", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
